// File: rtl/ec_pkg.sv
// Shared engine-controller constants and types for the input-buffer FIFO.
package ec_pkg;
  localparam int INBUF_MEM_DATA_W = 256;
  localparam int INBUF_MEM_ADDR_W = 6;
  localparam int INBUF_DEPTH      = 2 ** INBUF_MEM_ADDR_W;

  typedef logic [INBUF_MEM_DATA_W-1:0] inbuf_word_t;
  typedef logic [INBUF_MEM_ADDR_W-1:0] inbuf_ptr_t;
  typedef logic [INBUF_MEM_ADDR_W:0]   inbuf_cnt_t;
endpackage

// File: rtl/inbuf_sram_dp.sv
// Simple dual-port array: one write port, one registered read port with enable.
// The read register is the only reset state, so a foundry macro can drop in here.
module inbuf_sram_dp #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds between reads; only a hard reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/inbuf_fifo.sv
// Input-buffer FIFO between host DMA writes and controller pops; the occupancy
// count is the single source of truth for full/empty.
module inbuf_fifo
  import ec_pkg::*;
#(
  parameter int DATA_W = INBUF_MEM_DATA_W,
  parameter int ADDR_W = INBUF_MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eng_flush,
  input  logic              host_inbuf_wr_val,
  input  logic [DATA_W-1:0] host_inbuf_wr_data,
  output logic              inbuf_host_wr_rdy,
  input  logic              cntl_inbuf_fifo_rd_rq,
  input  logic              cntl_inbuf_fifo_mem_en,
  output logic              inbuf_fifo_cntl_empty,
  output logic              inbuf_fifo_full,
  output logic [ADDR_W:0]   inbuf_fifo_cnt,
  output logic [DATA_W-1:0] inbuf_fifo_rd_data,
  output logic              inbuf_fifo_rd_data_val,
  output logic              inbuf_fifo_ovf,
  output logic              inbuf_fifo_udf
);
  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              empty_q, full_q, rd_val_q, ovf_q, udf_q;
  logic              rd_try, wr_acc, rd_acc;

  assign rd_try = cntl_inbuf_fifo_rd_rq & cntl_inbuf_fifo_mem_en;
  // Flags are registered, so a full/empty FIFO never bypasses a same-cycle access.
  assign wr_acc = host_inbuf_wr_val & ~full_q & ~eng_flush;
  assign rd_acc = rd_try & ~empty_q & ~eng_flush;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || eng_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      rd_val_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == CNT_FULL);
      rd_val_q <= rd_acc;
      if (host_inbuf_wr_val && full_q) begin
        ovf_q <= 1'b1;
      end
      if (rd_try && empty_q) begin
        udf_q <= 1'b1;
      end
    end
  end

  inbuf_sram_dp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(host_inbuf_wr_data),
    .rd_en_i  (rd_acc),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(inbuf_fifo_rd_data)
  );

  assign inbuf_host_wr_rdy      = ~full_q;
  assign inbuf_fifo_cntl_empty  = empty_q;
  assign inbuf_fifo_full        = full_q;
  assign inbuf_fifo_cnt         = cnt_q;
  assign inbuf_fifo_rd_data_val = rd_val_q;
  assign inbuf_fifo_ovf         = ovf_q;
  assign inbuf_fifo_udf         = udf_q;
endmodule

// File: tb/tb_inbuf_fifo.sv
// Bench for inbuf_fifo: vector table, directed corner sequences, and a
// randomized run against a queue-based reference model.
module tb_inbuf_fifo;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         eng_flush = 1'b0;
  logic         wr_val = 1'b0;
  logic [255:0] wr_data = '0;
  logic         wr_rdy;
  logic         rd_rq = 1'b0;
  logic         mem_en = 1'b0;
  logic         empty, full, rd_val, ovf, udf;
  logic [6:0]   cnt;
  logic [255:0] rd_data;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [255:0] mq[$];
  logic [255:0] m_data = '0;
  logic         m_val = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  inbuf_fifo dut (
    .clk                   (clk),
    .rst                   (rst),
    .eng_flush             (eng_flush),
    .host_inbuf_wr_val     (wr_val),
    .host_inbuf_wr_data    (wr_data),
    .inbuf_host_wr_rdy     (wr_rdy),
    .cntl_inbuf_fifo_rd_rq (rd_rq),
    .cntl_inbuf_fifo_mem_en(mem_en),
    .inbuf_fifo_cntl_empty (empty),
    .inbuf_fifo_full       (full),
    .inbuf_fifo_cnt        (cnt),
    .inbuf_fifo_rd_data    (rd_data),
    .inbuf_fifo_rd_data_val(rd_val),
    .inbuf_fifo_ovf        (ovf),
    .inbuf_fifo_udf        (udf)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, sample 1ns after the edge.
  task automatic do_cycle(input logic r, input logic fl, input logic wv,
                          input logic [255:0] wd, input logic rq, input logic me);
    logic m_full, m_empty;
    rst = r; eng_flush = fl; wr_val = wv; wr_data = wd; rd_rq = rq; mem_en = me;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_data = '0; m_val = 0; m_ovf = 0; m_udf = 0;
    end else if (fl) begin
      mq.delete(); m_val = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_full  = (mq.size() == 64);
      m_empty = (mq.size() == 0);
      if (wv && m_full) m_ovf = 1;
      if (rq && me && m_empty) m_udf = 1;
      m_val = 0;
      if (rq && me && !m_empty) begin
        m_data = mq.pop_front();
        m_val = 1;
      end
      if (wv && !m_full) mq.push_back(wd);
    end
    #1;
    rst = 0; eng_flush = 0; wr_val = 0; rd_rq = 0; mem_en = 0;
  endtask

  task automatic chk_model();
    chk("m_cnt", 256'(cnt), 256'(mq.size()));
    chk("m_empty", 256'(empty), 256'(mq.size() == 0));
    chk("m_full", 256'(full), 256'(mq.size() == 64));
    chk("m_wr_rdy", 256'(wr_rdy), 256'(mq.size() != 64));
    chk("m_val", 256'(rd_val), 256'(m_val));
    chk("m_data", rd_data, m_data);
    chk("m_ovf", 256'(ovf), 256'(m_ovf));
    chk("m_udf", 256'(udf), 256'(m_udf));
  endtask

  task automatic wr(input logic [255:0] d);
    do_cycle(0, 0, 1, d, 0, 0);
  endtask

  task automatic rd();
    do_cycle(0, 0, 0, '0, 1, 1);
  endtask

  task automatic reset2();
    do_cycle(1, 0, 0, '0, 0, 0);
    do_cycle(1, 0, 0, '0, 0, 0);
  endtask

  typedef struct {
    logic        wv;
    logic [15:0] wd;
    logic        rq;
    logic        me;
    int          exp_cnt;
    logic        exp_empty;
    logic        exp_val;
    logic [15:0] exp_data;
    logic        exp_udf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [255:0] rnd;
    int mode;

    // Reset
    reset2();
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_full", 256'(full), 256'(0));
    chk("rst_cnt", 256'(cnt), 256'(0));
    chk("rst_wr_rdy", 256'(wr_rdy), 256'(1));
    chk("rst_val", 256'(rd_val), 256'(0));
    chk("rst_ovf", 256'(ovf), 256'(0));
    chk("rst_udf", 256'(udf), 256'(0));
    chk("rst_data", rd_data, '0);

    // Ordering, then rd+wr on empty, then rd_rq without mem_en
    vecs[0] = '{1, 16'hA1, 0, 0, 1, 0, 0, 16'h00, 0};
    vecs[1] = '{1, 16'hA2, 0, 0, 2, 0, 0, 16'h00, 0};
    vecs[2] = '{1, 16'hA3, 0, 0, 3, 0, 0, 16'h00, 0};
    vecs[3] = '{0, 16'h00, 1, 1, 2, 0, 1, 16'hA1, 0};
    vecs[4] = '{0, 16'h00, 1, 1, 1, 0, 1, 16'hA2, 0};
    vecs[5] = '{0, 16'h00, 1, 1, 0, 1, 1, 16'hA3, 0};
    vecs[6] = '{0, 16'h00, 0, 0, 0, 1, 0, 16'hA3, 0};
    vecs[7] = '{1, 16'hB0, 1, 1, 1, 0, 0, 16'hA3, 1};
    vecs[8] = '{0, 16'h00, 1, 0, 1, 0, 0, 16'hA3, 1};
    for (int i = 0; i < 9; i++) begin
      do_cycle(0, 0, vecs[i].wv, 256'(vecs[i].wd), vecs[i].rq, vecs[i].me);
      $display("vec %0d: wr=%0b rd=%0b en=%0b -> cnt=%0d val=%0b data=%0h udf=%0b",
               i, vecs[i].wv, vecs[i].rq, vecs[i].me, cnt, rd_val, rd_data, udf);
      chk("vec_cnt", 256'(cnt), 256'(vecs[i].exp_cnt));
      chk("vec_empty", 256'(empty), 256'(vecs[i].exp_empty));
      chk("vec_val", 256'(rd_val), 256'(vecs[i].exp_val));
      chk("vec_data", rd_data, 256'(vecs[i].exp_data));
      chk("vec_udf", 256'(udf), 256'(vecs[i].exp_udf));
    end

    // Full, overflow, rd+wr while full, drain
    reset2();
    for (int i = 0; i < 64; i++) begin
      wr(256'(i));
      chk_model();
    end
    chk("full_cnt", 256'(cnt), 256'(64));
    chk("full_flag", 256'(full), 256'(1));
    chk("full_wr_rdy", 256'(wr_rdy), 256'(0));
    wr(256'hDEAD);
    chk("ovf_set", 256'(ovf), 256'(1));
    chk("ovf_cnt", 256'(cnt), 256'(64));
    do_cycle(0, 0, 1, 256'hBEEF, 1, 1);
    chk("fullrw_cnt", 256'(cnt), 256'(63));
    chk("fullrw_val", 256'(rd_val), 256'(1));
    chk("fullrw_data", rd_data, 256'(0));
    chk("fullrw_full", 256'(full), 256'(0));
    for (int i = 1; i < 64; i++) begin
      rd();
      chk("drain_data", rd_data, 256'(i));
      chk("drain_val", 256'(rd_val), 256'(1));
    end
    chk("drain_cnt", 256'(cnt), 256'(0));
    chk("drain_empty", 256'(empty), 256'(1));
    chk("drain_ovf", 256'(ovf), 256'(1));

    // Wrap across index 63 -> 0
    reset2();
    for (int i = 0; i < 60; i++) wr(256'(i + 1000));
    for (int i = 0; i < 60; i++) rd();
    for (int i = 0; i < 10; i++) wr(256'(32'h100 + i));
    chk("wrap_cnt10", 256'(cnt), 256'(10));
    for (int i = 0; i < 10; i++) begin
      rd();
      chk("wrap_data", rd_data, 256'(32'h100 + i));
    end
    chk("wrap_cnt0", 256'(cnt), 256'(0));

    // rd+wr at cnt=5
    reset2();
    for (int i = 0; i < 5; i++) wr(256'(i + 16'h50));
    do_cycle(0, 0, 1, 256'h77, 1, 1);
    chk("mid_cnt", 256'(cnt), 256'(5));
    chk("mid_data", rd_data, 256'(16'h50));
    chk_model();

    // Flush with a read and a write in the same cycle clears state and sticky flags
    reset2();
    rd();
    chk("pre_udf", 256'(udf), 256'(1));
    for (int i = 0; i < 10; i++) wr(256'(i + 16'h300));
    rd();
    chk("pre_data", rd_data, 256'(16'h300));
    do_cycle(0, 1, 1, 256'h999, 1, 1);
    chk("fl_val", 256'(rd_val), 256'(0));
    chk("fl_cnt", 256'(cnt), 256'(0));
    chk("fl_empty", 256'(empty), 256'(1));
    chk("fl_udf", 256'(udf), 256'(0));
    chk("fl_data_hold", rd_data, 256'(16'h300));
    wr(256'h444);
    do_cycle(0, 0, 0, '0, 1, 0);
    chk("noen_cnt", 256'(cnt), 256'(1));
    chk("noen_val", 256'(rd_val), 256'(0));
    rd();
    chk("postfl_data", rd_data, 256'h444);

    // Randomized run against the model
    reset2();
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      mode = (c / 150) % 3;
      do_cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0),
               (mode == 0) ? ($urandom_range(0, 9) < 9) : (mode == 1) ? ($urandom_range(0, 9) < 2)
                                                                     : ($urandom_range(0, 1) == 1),
               rnd,
               (mode == 1) ? ($urandom_range(0, 9) < 9) : (mode == 0) ? ($urandom_range(0, 9) < 2)
                                                                     : ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 99) < 85));
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
